spi_master_core: RTL and testbench
==================================

SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 Parameter DATA_W, default 16: SPI word width in bits, range 4..32.
REQ-002 Parameter DIV_W, default 6: width of the divider input.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 nRst  input  1  reset, synchronous, active-low.
REQ-005 divider  input  DIV_W  SCK half-period minus one, in clk cycles.
REQ-006 cpol  input  1  SCK idle level.
REQ-007 cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-008 tData  input  DATA_W  word to transmit.
REQ-009 tRequest  input  1  transmit request, level, held until tDone.
REQ-010 tDone  output  1  one-cycle pulse: tData accepted.
REQ-011 rData  output  DATA_W  last received word.
REQ-012 rRequest  output  1  rData valid, held until rDone.
REQ-013 rDone  input  1  consumer acknowledge of rData.
REQ-014 overflow  output  1  sticky: a received word was dropped.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 sck, mosi, nCS  output  1 each  SPI master pins; miso  input  1.

Function
REQ-017 Half-period tick: counter reloads with latched divider, decrements each clk, and ticks when it reaches 0, so one half-period = divider+1 clk cycles (divider=0 gives clk/2 SCK).
REQ-018 States: IDLE, LEAD, SHIFT, TRAIL, GAP; state advances only on tick, except IDLE.
REQ-019 IDLE: when tRequest=1, latch tData, divider, cpol, cpha; assert tDone for that single cycle; nCS low next cycle; enter LEAD.
REQ-020 divider, cpol and cpha changes during a transfer are ignored until the next IDLE acceptance.
REQ-021 LEAD: one half-period, sck=cpol; for cpha=0, mosi=MSB of word from nCS fall.
REQ-022 SHIFT: 2*DATA_W half-periods; sck toggles on each tick, first toggle = leading edge; ends with sck=cpol.
REQ-023 cpha=0: sample miso on leading edges, shift mosi to next bit on trailing edges.
REQ-024 cpha=1: shift mosi to next bit (first: MSB) on leading edges, sample miso on trailing edges.
REQ-025 Bit order MSB first for both directions; exactly DATA_W samples taken per word.
REQ-026 TRAIL: one half-period with nCS low and sck=cpol, then nCS high and enter GAP.
REQ-027 GAP: one half-period with nCS high, then IDLE; minimum nCS-high time = divider+1 cycles.
REQ-028 Total transfer, tDone to return to IDLE = (divider+1)*(2*DATA_W+3) cycles.
REQ-029 On TRAIL exit: if rRequest=0, load rData with the received word and set rRequest; otherwise keep rData, drop the word, and set overflow.
REQ-030 rRequest clears on the cycle after rDone=1 is sampled; when clear and load coincide, the load wins and rRequest stays high.
REQ-031 overflow clears only on reset.
REQ-032 tRequest outside IDLE is ignored; back-to-back requests start in the cycle after GAP ends.
REQ-033 mosi is driven 0 when nCS=1.

Reset
REQ-034 nRst=0 at a rising clk edge: state IDLE, nCS=1, sck=0, mosi=0, tDone=0, rRequest=0, rData=0, overflow=0, busy=0, counters 0.
REQ-035 Reset mid-transfer aborts immediately; no partial word reaches rData.
REQ-036 After reset, the first transfer uses the cpol sampled at acceptance; sck goes to cpol from LEAD onward.

Verification
REQ-037 DATA_W=16, divider=3, mode 0, tData=16'hA55A, miso loops to mosi -> tDone single pulse; sck period 8 clk; rData=16'hA55A; transfer length 140 clk.
REQ-038 Modes 1, 2, 3 with a slave model sending 16'h1234 -> rData=16'h1234; sck idles at cpol; mosi sampled by the model equals tData.
REQ-039 divider=0, back-to-back tRequest with 3 words, rDone held 1 -> 3 transfers; nCS high exactly 1 clk between them; no overflow.
REQ-040 rDone held 0, 2 transfers -> rData holds first word; overflow=1 after second TRAIL and remains 1.
REQ-041 nRst pulsed in SHIFT mid-word -> outputs at reset values next cycle; next transfer completes correctly.
REQ-042 divider changed during SHIFT -> current word keeps its old timing; next word uses the new divider.

Source files
------------

// File: rtl/spi_master_core.sv
// spi_master_core: single-word SPI master with programmable SCK divider,
// all four CPOL/CPHA modes, request/done handshakes and sticky overflow.
// Ports: clk, nRst (sync, active-low); divider/cpol/cpha/tData/tRequest in,
// tDone out; rData/rRequest out, rDone in; overflow, busy out;
// sck/mosi/nCS out, miso in.
module spi_master_core #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 6
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [DIV_W-1:0]  divider,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tData,
  input  logic              tRequest,
  output logic              tDone,
  output logic [DATA_W-1:0] rData,
  output logic              rRequest,
  input  logic              rDone,
  output logic              overflow,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  output logic              nCS,
  input  logic              miso
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] EDGES = EW'(2 * DATA_W);

  typedef enum logic [2:0] {
    IDLE, LEAD, SHIFT, TRAIL, GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rreq_q, rreq_d;
  logic              ovf_q, ovf_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ncs_q, ncs_d;

  logic tick;
  logic accept;
  logic edge_en;
  logic do_shift;
  logic do_sample;

  always_comb begin
    tick = (state_q != IDLE) && (cnt_q == '0);
    // A pending request is taken on the last GAP cycle too, so a
    // back-to-back word keeps nCS high for exactly one half-period.
    accept = nRst && tRequest &&
             ((state_q == IDLE) || ((state_q == GAP) && tick));
    edge_en = tick && (edge_q < EDGES) &&
              ((state_q == LEAD) || (state_q == SHIFT));
    // Even edge count = leading edge; cpha picks which edge shifts.
    do_shift  = edge_en && (!edge_q[0] == cpha_q);
    do_sample = edge_en && (!edge_q[0] != cpha_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rreq_d  = rreq_q;
    ovf_d   = ovf_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ncs_d   = ncs_q;

    if (tick) begin
      cnt_d = div_q;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    if (edge_en) begin
      sck_d  = ~sck_q;
      edge_d = edge_q + EW'(1);
    end
    if (do_shift) begin
      mosi_d = tx_q[DATA_W-1];
      tx_d   = {tx_q[DATA_W-2:0], 1'b0};
    end
    if (do_sample) begin
      rx_d = {rx_q[DATA_W-2:0], miso};
    end

    if (rDone) begin
      rreq_d = 1'b0;
    end

    unique case (state_q)
      IDLE: ;
      LEAD: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick && (edge_q == EDGES)) state_d = TRAIL;
      end
      TRAIL: begin
        if (tick) begin
          state_d = GAP;
          ncs_d   = 1'b1;
          mosi_d  = 1'b0;
          // A word acknowledged this very cycle frees the slot.
          if (!rreq_q || rDone) begin
            rdata_d = rx_q;
            rreq_d  = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = LEAD;
      cnt_d   = divider;
      div_d   = divider;
      cpol_d  = cpol;
      cpha_d  = cpha;
      edge_d  = '0;
      rx_d    = '0;
      ncs_d   = 1'b0;
      sck_d   = cpol;
      // cpha=0 presents the MSB at nCS fall, so the
      // shifter starts one bit ahead.
      if (cpha) begin
        tx_d   = tData;
        mosi_d = 1'b0;
      end else begin
        tx_d   = {tData[DATA_W-2:0], 1'b0};
        mosi_d = tData[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rreq_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ncs_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rreq_q  <= rreq_d;
      ovf_q   <= ovf_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ncs_q   <= ncs_d;
    end
  end

  assign tDone    = accept;
  assign rData    = rdata_q;
  assign rRequest = rreq_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign nCS      = ncs_q;

endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: directed bench for spi_master_core with an SPI
// slave model and a mosi->miso loopback option.
module tb_spi_master_core;

  logic        clk;
  logic        nRst;
  logic [5:0]  divider;
  logic        cpol;
  logic        cpha;
  logic [15:0] tData;
  logic        tRequest;
  logic        tDone;
  logic [15:0] rData;
  logic        rRequest;
  logic        rDone;
  logic        overflow;
  logic        busy;
  logic        sck;
  logic        mosi;
  logic        nCS;
  logic        miso;

  int checks = 0;
  int errors = 0;
  int tdone_cnt = 0;

  logic        loopback;
  logic        miso_s;
  logic        s_cpol;
  logic        s_cpha;
  logic        s_lead;
  logic [15:0] s_word;
  logic [15:0] s_rx;
  int          s_idx;

  assign miso = loopback ? mosi : miso_s;

  spi_master_core #(.DATA_W(16), .DIV_W(6)) dut (
    .clk(clk), .nRst(nRst), .divider(divider),
    .cpol(cpol), .cpha(cpha), .tData(tData),
    .tRequest(tRequest), .tDone(tDone), .rData(rData),
    .rRequest(rRequest), .rDone(rDone),
    .overflow(overflow), .busy(busy), .sck(sck),
    .mosi(mosi), .nCS(nCS), .miso(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (tDone) tdone_cnt++;

  // Slave model: leading edge = sck moving away from its idle level.
  always @(negedge nCS) begin
    s_idx = 0;
    s_rx  = '0;
    miso_s = s_cpha ? 1'b0 : s_word[15];
  end
  always @(posedge nCS) s_lead = 1'b0;
  always @(sck) begin
    if (!nCS) begin
      if (sck != s_cpol) begin
        s_lead = 1'b1;
        if (!s_cpha) s_rx = {s_rx[14:0], mosi};
        else begin
          miso_s = (s_idx < 16) ? s_word[15-s_idx] : 1'b0;
          s_idx++;
        end
      end else if (s_lead) begin
        if (!s_cpha) begin
          s_idx++;
          miso_s = (s_idx < 16) ? s_word[15-s_idx] : 1'b0;
        end else s_rx = {s_rx[14:0], mosi};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    @(negedge clk); rDone = 1'b1;
    @(negedge clk); rDone = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] d, input logic [5:0] dv,
                      input logic p, input logic h,
                      input int chg_at, input logic [5:0] chg_dv,
                      output int bc, output int ed, output int per);
    int t;
    int r1;
    int r2;
    logic ps;
    @(negedge clk);
    tData = d; divider = dv; cpol = p; cpha = h;
    s_cpol = p; s_cpha = h; tRequest = 1'b1;
    #1;
    t = 0;
    while (!tDone && t < 20) begin @(negedge clk); #1; t++; end
    @(posedge clk); #1;
    tRequest = 1'b0;
    bc = 0; ed = 0; r1 = -1; r2 = -1; ps = sck;
    while (busy && bc < 5000) begin
      if (bc == chg_at) divider = chg_dv;
      bc++;
      @(posedge clk); #1;
      if (sck != ps) begin
        ed++;
        if (sck && r1 < 0) r1 = bc;
        else if (sck && r2 < 0) r2 = bc;
      end
      ps = sck;
    end
    per = r2 - r1;
  endtask

  initial begin
    int bc, ed, per, n0;
    int acc, got, runs, hr, bad_run, cyc;
    logic tk, seen_low;
    logic [15:0] bw [3];
    logic [15:0] rxw [3];

    nRst = 1'b0; divider = 6'd3; cpol = 1'b0; cpha = 1'b0;
    tData = '0; tRequest = 1'b0; rDone = 1'b0;
    loopback = 1'b1; s_cpol = 1'b0; s_cpha = 1'b0;
    s_lead = 1'b0; s_word = 16'h1234; s_rx = '0;
    s_idx = 0; miso_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ncs", nCS, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_tdone", tDone, 0);
    chk("rst_rreq", rRequest, 0);
    chk("rst_rdata", rData, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    nRst = 1'b1;

    // Mode 0 loopback, divider 3.
    n0 = tdone_cnt;
    xfer(16'hA55A, 6'd3, 0, 0, -1, 6'd0, bc, ed, per);
    chk("m0_tdone", tdone_cnt - n0, 1);
    chk("m0_len", bc, 140);
    chk("m0_edges", ed, 32);
    chk("m0_period", per, 8);
    chk("m0_rdata", rData, 16'hA55A);
    chk("m0_rreq", rRequest, 1);
    chk("m0_ovf", overflow, 0);
    chk("m0_mosi_idle", mosi, 0);
    chk("m0_ncs_idle", nCS, 1);
    ack();
    #1;
    chk("m0_rreq_clr", rRequest, 0);

    // Modes 1..3 against the slave model.
    loopback = 1'b0;
    xfer(16'hC3A5, 6'd1, 0, 1, -1, 6'd0, bc, ed, per);
    chk("m1_len", bc, 70);
    chk("m1_rdata", rData, 16'h1234);
    chk("m1_slave", s_rx, 16'hC3A5);
    chk("m1_sck_idle", sck, 0);
    chk("m1_period", per, 4);
    ack();
    xfer(16'h5A0F, 6'd2, 1, 0, -1, 6'd0, bc, ed, per);
    chk("m2_len", bc, 105);
    chk("m2_rdata", rData, 16'h1234);
    chk("m2_slave", s_rx, 16'h5A0F);
    chk("m2_sck_idle", sck, 1);
    chk("m2_edges", ed, 32);
    ack();
    xfer(16'h0FF0, 6'd0, 1, 1, -1, 6'd0, bc, ed, per);
    chk("m3_len", bc, 35);
    chk("m3_rdata", rData, 16'h1234);
    chk("m3_slave", s_rx, 16'h0FF0);
    chk("m3_sck_idle", sck, 1);
    ack();

    // Back-to-back, divider 0, rDone held high.
    loopback = 1'b1; rDone = 1'b1;
    divider = 6'd0; cpol = 1'b0; cpha = 1'b0;
    s_cpol = 1'b0; s_cpha = 1'b0;
    bw[0] = 16'h0F1E; bw[1] = 16'h8001; bw[2] = 16'h7FFE;
    rxw[0] = '0; rxw[1] = '0; rxw[2] = '0;
    acc = 0; got = 0; runs = 0; hr = 0; bad_run = 0; cyc = 0;
    seen_low = 1'b0;
    @(posedge clk); #1;
    tData = bw[0]; tRequest = 1'b1;
    while ((acc < 3 || busy) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      tk = tDone;
      if (!nCS) begin
        if (hr > 0) begin
          runs++;
          if (hr != 1) bad_run++;
        end
        hr = 0; seen_low = 1'b1;
      end else if (seen_low) hr++;
      if (rRequest) begin
        if (got < 3) rxw[got] = rData;
        got++;
      end
      @(posedge clk); #1;
      if (tk) begin
        acc++;
        if (acc < 3) tData = bw[acc];
        else tRequest = 1'b0;
      end
    end
    chk("b2b_accepts", acc, 3);
    chk("b2b_gaps", runs, 2);
    chk("b2b_gap_len", bad_run, 0);
    chk("b2b_words", got, 3);
    chk("b2b_w0", rxw[0], bw[0]);
    chk("b2b_w1", rxw[1], bw[1]);
    chk("b2b_w2", rxw[2], bw[2]);
    chk("b2b_ovf", overflow, 0);
    chk("b2b_cycles", cyc, 106);
    rDone = 1'b0;

    // Overflow: two words, no acknowledge.
    xfer(16'h1111, 6'd1, 0, 0, -1, 6'd0, bc, ed, per);
    chk("ov_rdata1", rData, 16'h1111);
    chk("ov_ovf1", overflow, 0);
    xfer(16'h2222, 6'd1, 0, 0, -1, 6'd0, bc, ed, per);
    chk("ov_rdata2", rData, 16'h1111);
    chk("ov_ovf2", overflow, 1);
    repeat (5) @(posedge clk);
    ack();
    #1;
    chk("ov_sticky", overflow, 1);
    chk("ov_rreq_clr", rRequest, 0);

    // Reset mid-word.
    @(negedge clk);
    tData = 16'hBEEF; divider = 6'd2; cpol = 1'b0; cpha = 1'b0;
    s_cpol = 1'b0; s_cpha = 1'b0; tRequest = 1'b1;
    @(posedge clk); #1;
    tRequest = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rs_busy_pre", busy, 1);
    nRst = 1'b0;
    @(posedge clk); #1;
    nRst = 1'b1;
    chk("rs_ncs", nCS, 1);
    chk("rs_sck", sck, 0);
    chk("rs_mosi", mosi, 0);
    chk("rs_busy", busy, 0);
    chk("rs_rdata", rData, 0);
    chk("rs_ovf", overflow, 0);
    chk("rs_rreq", rRequest, 0);
    xfer(16'h6C3E, 6'd1, 0, 0, -1, 6'd0, bc, ed, per);
    chk("rs_len", bc, 70);
    chk("rs_after", rData, 16'h6C3E);
    ack();

    // Divider change mid-word.
    xfer(16'h5AC3, 6'd1, 0, 0, 20, 6'd5, bc, ed, per);
    chk("dv_old_len", bc, 70);
    chk("dv_old_per", per, 4);
    chk("dv_old_rdata", rData, 16'h5AC3);
    ack();
    xfer(16'h3C5A, 6'd5, 0, 0, -1, 6'd0, bc, ed, per);
    chk("dv_new_len", bc, 210);
    chk("dv_new_per", per, 12);
    chk("dv_new_rdata", rData, 16'h3C5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
